// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic ORDER_LSB_FIRST = 1'b0;
   localparam logic ORDER_MSB_FIRST = 1'b1;

   // Degenerate widths still get a one-bit counter so port ranges stay legal.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit index counter: counts 0..WIDTH-1, wraps to 0, and flags the last bit.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int CW = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

   assign last = (cnt == LAST_VAL);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Serializes a WIDTH-bit word onto d_sout, one bit per clk, with gap-free
// back-to-back frames when a new word is offered during the last-bit cycle.
//
//   state | meaning
//   IDLE  | no frame active, d_sout parked at IDLE_LEVEL, ready for a word
//   SHIFT | frame bits on d_sout; cnt is the index of the bit currently shown
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_pin,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             d_sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             handshake;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST == ORDER_MSB_FIRST) ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return (MSB_FIRST == ORDER_MSB_FIRST) ? (w << 1) : (w >> 1);
   endfunction

   assign load_ready = !rst && ((state == IDLE) || ((state == SHIFT) && last));
   assign handshake  = load_valid && load_ready;
   assign busy       = (state == SHIFT);
   assign sout_valid = busy;

   piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (handshake),
      .enable (state == SHIFT),
      .cnt    (cnt),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (handshake) state_nxt = SHIFT;
         SHIFT:   if (last && !handshake) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // d_sout is loaded with the bit to show next; sreg keeps the bits still to come.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg        <= '0;
         d_sout      <= IDLE_LEVEL;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_start <= handshake;
         frame_done  <= (state == SHIFT) && !last && (cnt == PENULT);
         if (handshake) begin
            sreg   <= advance(d_pin);
            d_sout <= first_bit(d_pin);
         end else if (state == SHIFT && !last) begin
            sreg   <= advance(sreg);
            d_sout <= first_bit(sreg);
         end else if (state == SHIFT) begin
            d_sout <= IDLE_LEVEL;
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: per-cycle vector table on an MSB-first and an
// LSB-first instance sharing stimulus, then a loopback into a small SIPO model.
module tb_piso_serializer;

   localparam int W = 4;

   typedef struct {
      logic         rst;
      logic         vld;
      logic [W-1:0] din;
      logic         rdy;
      logic         sm;
      logic         sl;
      logic         sv;
      logic         fs;
      logic         fd;
      logic         bsy;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] d_pin = '0;
   logic         load_valid = 1'b0;

   logic rdy_m, sout_m, sv_m, fs_m, fd_m, busy_m;
   logic rdy_l, sout_l, sv_l, fs_l, fd_l, busy_l;

   logic [W-1:0] sipo_q;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
      .clk         (clk),
      .rst         (rst),
      .d_pin       (d_pin),
      .load_valid  (load_valid),
      .load_ready  (rdy_m),
      .d_sout      (sout_m),
      .sout_valid  (sv_m),
      .frame_start (fs_m),
      .frame_done  (fd_m),
      .busy        (busy_m)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
      .clk         (clk),
      .rst         (rst),
      .d_pin       (d_pin),
      .load_valid  (load_valid),
      .load_ready  (rdy_l),
      .d_sout      (sout_l),
      .sout_valid  (sv_l),
      .frame_start (fs_l),
      .frame_done  (fd_l),
      .busy        (busy_l)
   );

   // Downstream SIPO model: MSB-first stream shifts in from the right.
   always_ff @(posedge clk) begin
      if (rst) begin
         sipo_q <= '0;
      end else if (sv_m) begin
         sipo_q <= {sipo_q[W-2:0], sout_m};
      end
   end

   task automatic chk(input string name, input int row, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: actual %0h required %0h", name, row, act, exp);
      end
   endtask

   vec_t tbl[$];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //                rst   vld   din      rdy   sm    sl    sv    fs    fd    bsy
      tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      // single frame 1011
      tbl.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      // back-to-back 1011 then 0110, valid held with junk words in between
      tbl.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      // reset after two bits of 1011, then 0101
      tbl.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst        = tbl[i].rst;
         load_valid = tbl[i].vld;
         d_pin      = tbl[i].din;
         #1;
         chk("load_ready_msb", i, {3'b0, rdy_m}, {3'b0, tbl[i].rdy});
         chk("load_ready_lsb", i, {3'b0, rdy_l}, {3'b0, tbl[i].rdy});
         @(posedge clk);
         #1;
         chk("d_sout_msb",  i, {3'b0, sout_m}, {3'b0, tbl[i].sm});
         chk("d_sout_lsb",  i, {3'b0, sout_l}, {3'b0, tbl[i].sl});
         chk("sout_valid",  i, {3'b0, sv_m},   {3'b0, tbl[i].sv});
         chk("frame_start", i, {3'b0, fs_m},   {3'b0, tbl[i].fs});
         chk("frame_done",  i, {3'b0, fd_m},   {3'b0, tbl[i].fd});
         chk("busy",        i, {3'b0, busy_m}, {3'b0, tbl[i].bsy});
         chk("lsb_flags",   i, {1'b0, sv_l, fs_l, fd_l}, {1'b0, tbl[i].sv, tbl[i].fs, tbl[i].fd});
      end

      // Loopback: after frame_done, the SIPO holds the word on the following cycle.
      begin
         logic [W-1:0] words [2];
         words[0] = 4'b1011;
         words[1] = 4'b0110;
         for (int k = 0; k < 2; k++) begin
            logic seen;
            @(negedge clk);
            rst        = 1'b0;
            load_valid = 1'b1;
            d_pin      = words[k];
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            d_pin      = '0;
            seen       = 1'b0;
            for (int c = 0; c < 8; c++) begin
               if (!seen) begin
                  @(posedge clk);
                  #1;
                  if (fd_m) seen = 1'b1;
               end
            end
            chk("loop_frame_done_seen", k, {3'b0, seen}, 4'b0001);
            @(posedge clk);
            #1;
            chk("loop_sipo_q", k, sipo_q, words[k]);
            chk("loop_idle_after", k, {2'b0, sv_m, sout_m}, 4'b0000);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
